// File: rtl/pbch_pkg.sv
// Shared constants and types for the PBCH QPSK LLR demapper.
package pbch_pkg;

    localparam int EQ_WORD_LENGTH    = 8;    // equalized sample width, S0.(EQ_WORD_LENGTH-1)
    localparam int LLR_WORD_LENGTH   = 6;    // LLR width, signed two's complement
    localparam int PBCH_RE_NUM       = 432;  // PBCH data REs per SSB
    localparam int PBCH_ADDR_WIDTH   = 9;    // ceil(log2(PBCH_RE_NUM))
    localparam int LLR_MAG_SUM_WIDTH = 18;   // width of the optional LLR magnitude accumulator

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2
    } demap_state_t;

endpackage

// File: rtl/pbch_qpsk_llr_demapper_llr_sat_shift.sv
// Combinational arithmetic right shift followed by a symmetric saturation
// to [-(2^(L-1)-1), 2^(L-1)-1]; the most negative code is never produced.
module llr_sat_shift #(
    parameter int EQ_WORD_LENGTH  = pbch_pkg::EQ_WORD_LENGTH,
    parameter int LLR_WORD_LENGTH = pbch_pkg::LLR_WORD_LENGTH,
    parameter int LLR_SHIFT       = 0
) (
    input  logic signed [EQ_WORD_LENGTH-1:0]  x,
    output logic signed [LLR_WORD_LENGTH-1:0] llr
);
    import pbch_pkg::*;

    // One extra bit over the wider of the two formats keeps the compare exact.
    localparam int W = ((EQ_WORD_LENGTH > LLR_WORD_LENGTH) ? EQ_WORD_LENGTH : LLR_WORD_LENGTH) + 1;
    localparam logic signed [W-1:0] LLR_MAX = W'((1 << (LLR_WORD_LENGTH - 1)) - 1);
    localparam logic signed [W-1:0] LLR_MIN = -LLR_MAX;

    logic signed [EQ_WORD_LENGTH-1:0] shifted;
    logic signed [W-1:0]              wide;

    // Shift, sign-extend, then clamp; narrow inputs fall through unclamped.
    always_comb begin
        // NOTE: every output of a combinational block gets a value on every path, otherwise a latch is inferred.
        shifted = x >>> LLR_SHIFT;
        wide    = {{(W - EQ_WORD_LENGTH){shifted[EQ_WORD_LENGTH-1]}}, shifted};
        llr     = wide[LLR_WORD_LENGTH-1:0];
        if (wide > LLR_MAX) begin
            llr = LLR_MAX[LLR_WORD_LENGTH-1:0];
        end else if (wide < LLR_MIN) begin
            llr = LLR_MIN[LLR_WORD_LENGTH-1:0];
        end
    end

endmodule

// File: rtl/pbch_qpsk_llr_demapper.sv
// PBCH soft QPSK demapper: equalized I/Q -> saturated LLR pair written to the
// PBCH LLR buffer, one pair per RE, with a done pulse after the last of the SSB.
// Optional feature: define PBCH_LLR_STATS_EN to add the llr_mag_sum accumulator.
module pbch_qpsk_llr_demapper #(
    parameter int EQ_WORD_LENGTH  = pbch_pkg::EQ_WORD_LENGTH,
    parameter int LLR_WORD_LENGTH = pbch_pkg::LLR_WORD_LENGTH,
    parameter int LLR_SHIFT       = 0,
    parameter int PBCH_RE_NUM     = pbch_pkg::PBCH_RE_NUM,
    parameter int ADDR_WIDTH      = pbch_pkg::PBCH_ADDR_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic signed [EQ_WORD_LENGTH-1:0]  eq_i,
    input  logic signed [EQ_WORD_LENGTH-1:0]  eq_q,
    input  logic                              in_valid,
    output logic                              llr_wr_en,
    output logic [ADDR_WIDTH-1:0]             llr_addr,
    output logic [2*LLR_WORD_LENGTH-1:0]      llr_data,
    output logic                              demap_done,
    output logic                              busy,
`ifdef PBCH_LLR_STATS_EN
    output logic [pbch_pkg::LLR_MAG_SUM_WIDTH-1:0] llr_mag_sum,
`endif
    output logic                              err_overrun
);
    import pbch_pkg::*;

    localparam int L = LLR_WORD_LENGTH;

    demap_state_t          state, state_next;
    logic [ADDR_WIDTH-1:0] re_cnt, re_cnt_next;
    logic [ADDR_WIDTH-1:0] re_idx;
    logic                  accept;
    logic                  last_re;
    logic signed [L-1:0]   llr_b0, llr_b1;

    llr_sat_shift #(
        .EQ_WORD_LENGTH (EQ_WORD_LENGTH),
        .LLR_WORD_LENGTH(LLR_WORD_LENGTH),
        .LLR_SHIFT      (LLR_SHIFT)
    ) u_sat_i (
        .x  (eq_i),
        .llr(llr_b0)
    );

    llr_sat_shift #(
        .EQ_WORD_LENGTH (EQ_WORD_LENGTH),
        .LLR_WORD_LENGTH(LLR_WORD_LENGTH),
        .LLR_SHIFT      (LLR_SHIFT)
    ) u_sat_q (
        .x  (eq_q),
        .llr(llr_b1)
    );

    // A start in the same cycle as in_valid arms the SSB and takes that RE as index 0.
    assign accept  = in_valid && (start || (state == COLLECT));
    assign re_idx  = start ? '0 : re_cnt;
    assign last_re = accept && (re_idx == ADDR_WIDTH'(PBCH_RE_NUM - 1));
    assign busy    = (state == COLLECT);

    // Next state and RE counter.
    always_comb begin
        state_next  = state;
        re_cnt_next = re_cnt;
        case (state)
            IDLE, COLLECT: state_next = state;
            DONE:          state_next = IDLE;
            default:       state_next = IDLE;
        endcase
        if (start) begin
            state_next  = COLLECT;
            re_cnt_next = '0;
        end
        if (accept) begin
            if (last_re) begin
                state_next  = DONE;
                re_cnt_next = '0;
            end else begin
                re_cnt_next = re_idx + 1'b1;
            end
        end
    end

    // State, counter and the registered write port toward the LLR buffer.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state       <= IDLE;
            re_cnt      <= '0;
            llr_wr_en   <= 1'b0;
            llr_addr    <= '0;
            llr_data    <= '0;
            demap_done  <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            state      <= state_next;
            re_cnt     <= re_cnt_next;
            llr_wr_en  <= accept;
            demap_done <= (state == DONE);
            if (accept) begin
                llr_addr <= re_idx;
                llr_data <= {llr_b1, llr_b0};
            end
            if (start) begin
                err_overrun <= 1'b0;
            end else if (in_valid && !accept) begin
                err_overrun <= 1'b1;
            end
        end
    end

`ifdef PBCH_LLR_STATS_EN
    localparam int SW = LLR_MAG_SUM_WIDTH;

    logic [L-1:0]  mag_b0, mag_b1;
    logic [SW-1:0] sum_base;
    logic [SW:0]   sum_wide;
    logic [SW-1:0] sum_next;

    // |llr| never overflows L bits because saturation is symmetric.
    always_comb begin
        mag_b0   = llr_b0[L-1] ? -llr_b0 : llr_b0;
        mag_b1   = llr_b1[L-1] ? -llr_b1 : llr_b1;
        sum_base = start ? '0 : llr_mag_sum;
        sum_wide = {1'b0, sum_base} + (SW + 1)'(mag_b0) + (SW + 1)'(mag_b1);
        sum_next = sum_wide[SW] ? '1 : sum_wide[SW-1:0];
    end

    // Accumulate alongside the write; holds after the SSB until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            llr_mag_sum <= '0;
        end else if (accept) begin
            llr_mag_sum <= sum_next;
        end else if (start) begin
            llr_mag_sum <= '0;
        end
    end
`else
    // Statistics disabled: no accumulator and no llr_mag_sum port.
`endif

endmodule

// File: tb/tb_pbch_qpsk_llr_demapper.sv
// Self-checking bench for pbch_qpsk_llr_demapper. Two instances share stimulus:
// LLR_SHIFT=0 and LLR_SHIFT=2. Optional PBCH_LLR_STATS_EN checks llr_mag_sum.
module tb_pbch_qpsk_llr_demapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, in_valid;
    logic [7:0] eq_i, eq_q;

    logic        d0_wr_en, d0_done, d0_busy, d0_err;
    logic [8:0]  d0_addr;
    logic [11:0] d0_data;
    logic        d2_wr_en, d2_done, d2_busy, d2_err;
    logic [8:0]  d2_addr;
    logic [11:0] d2_data;
`ifdef PBCH_LLR_STATS_EN
    logic [17:0] d0_mag, d2_mag;
`endif

    pbch_qpsk_llr_demapper #(.LLR_SHIFT(0)) dut (
        .clk(clk), .rst(rst), .start(start), .eq_i(eq_i), .eq_q(eq_q), .in_valid(in_valid),
        .llr_wr_en(d0_wr_en), .llr_addr(d0_addr), .llr_data(d0_data), .demap_done(d0_done),
        .busy(d0_busy),
`ifdef PBCH_LLR_STATS_EN
        .llr_mag_sum(d0_mag),
`endif
        .err_overrun(d0_err)
    );

    pbch_qpsk_llr_demapper #(.LLR_SHIFT(2)) dut_s2 (
        .clk(clk), .rst(rst), .start(start), .eq_i(eq_i), .eq_q(eq_q), .in_valid(in_valid),
        .llr_wr_en(d2_wr_en), .llr_addr(d2_addr), .llr_data(d2_data), .demap_done(d2_done),
        .busy(d2_busy),
`ifdef PBCH_LLR_STATS_EN
        .llr_mag_sum(d2_mag),
`endif
        .err_overrun(d2_err)
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [11:0] pair(input int b1, input int b0);
        return {6'(b1), 6'(b0)};
    endfunction

    // Write monitor on the SHIFT=0 instance: counts writes/done pulses and
    // flags any address that is not contiguous within the current SSB.
    int         seg_id = 0;
    bit         mon_chk_data = 1'b0;
    logic [11:0] mon_exp_data = '0;
    int cyc = 0, mon_seg = 0, mon_exp_addr = 0;
    int mon_wr = 0, mon_done = 0, mon_bad = 0, mon_last_wr = 0, mon_done_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (mon_seg != seg_id) begin
            mon_seg      = seg_id;
            mon_exp_addr = 0;
        end
        if (d0_wr_en) begin
            if (d0_addr != 9'(mon_exp_addr)) mon_bad++;
            if (mon_chk_data && (d0_data != mon_exp_data)) mon_bad++;
            mon_exp_addr++;
            mon_wr++;
            mon_last_wr = cyc;
        end
        if (d0_done) begin
            mon_done++;
            mon_done_cyc = cyc;
        end
    end

    int b_wr, b_done, b_bad;
    task automatic mark();
        b_wr = mon_wr; b_done = mon_done; b_bad = mon_bad;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        seg_id++;
    endtask

    task automatic feed(input int n, input bit gapped, input int vi, input int vq);
        int sent  = 0;
        int guard = 0;
        while (sent < n && guard < 20000) begin
            in_valid = gapped ? 1'($urandom_range(0, 1)) : 1'b1;
            eq_i = 8'(vi);
            eq_q = 8'(vq);
            if (in_valid) sent++;
            guard++;
            step();
        end
        in_valid = 1'b0;
        if (sent < n) check("feed_timeout", 32'(sent), 32'(n));
    endtask

    // Full-SSB result checks shared by the complete-SSB scenarios.
    task automatic check_ssb(input string tag);
        check({tag, "_writes"}, 32'(mon_wr - b_wr), 32'd432);
        check({tag, "_bad"}, 32'(mon_bad - b_bad), 32'd0);
        check({tag, "_done_cnt"}, 32'(mon_done - b_done), 32'd1);
        check({tag, "_done_pos"}, 32'(mon_done_cyc - mon_last_wr), 32'd1);
        check({tag, "_last_addr"}, 32'(d0_addr), 32'd431);
        check({tag, "_busy_end"}, 32'(d0_busy), 32'd0);
    endtask

    typedef struct {
        int eq_i, eq_q;
        int b0_s0, b1_s0, b0_s2, b1_s2;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{64, -64, 31, -31, 16, -16};
        tbl[1] = '{-128, 127, -31, 31, -31, 31};
        tbl[2] = '{8, -8, 8, -8, 2, -2};
        tbl[3] = '{32, -32, 31, -31, 8, -8};
        tbl[4] = '{31, -31, 31, -31, 7, -8};
        tbl[5] = '{-5, 0, -5, 0, -2, 0};
        tbl[6] = '{124, -124, 31, -31, 31, -31};
        tbl[7] = '{123, -123, 31, -31, 30, -31};
        tbl[8] = '{-1, 1, -1, 1, -1, 0};
        tbl[9] = '{-120, 127, -31, 31, -30, 31};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0; eq_i = '0; eq_q = '0;
        step();
        step();
        check("reset_outputs", 32'({d0_wr_en, d0_addr, d0_data, d0_done, d0_busy, d0_err}), 32'd0);
        rst = 1'b0;

        // in_valid before any start: dropped, overrun flagged
        mark();
        feed(3, 1'b0, 64, -64);
        step();
        check("pre_start_writes", 32'(mon_wr - b_wr), 32'd0);
        check("pre_start_err", 32'(d0_err), 32'd1);

        // full SSB, contiguous input
        do_start();
        check("start_clears_err", 32'(d0_err), 32'd0);
        check("busy_after_start", 32'(d0_busy), 32'd1);
        mon_chk_data = 1'b1;
        mon_exp_data = pair(-31, 31);
        mark();
        feed(432, 1'b0, 64, -64);
        wait_cycles(4);
        check_ssb("ssb1");

        // extra REs after done: no writes, sticky overrun
        mark();
        feed(3, 1'b0, 5, 5);
        wait_cycles(3);
        check("post_done_writes", 32'(mon_wr - b_wr), 32'd0);
        check("post_done_no_pulse", 32'(mon_done - b_done), 32'd0);
        check("post_done_err", 32'(d0_err), 32'd1);

        // LLR math table, both shift settings
        mon_chk_data = 1'b0;
        do_start();
        check("table_start_err", 32'(d0_err), 32'd0);
        for (int k = 0; k < 10; k++) begin
            eq_i = 8'(tbl[k].eq_i);
            eq_q = 8'(tbl[k].eq_q);
            in_valid = 1'b1;
            step();
            check($sformatf("tbl%0d_wr", k), 32'({d0_wr_en, d2_wr_en, d0_addr}), 32'({2'b11, 9'(k)}));
            check($sformatf("tbl%0d_data", k), 32'({d2_data, d0_data}),
                  32'({pair(tbl[k].b1_s2, tbl[k].b0_s2), pair(tbl[k].b1_s0, tbl[k].b0_s0)}));
        end
        in_valid = 1'b0;

        // gapped input
        do_start();
        mon_chk_data = 1'b1;
        mon_exp_data = pair(31, -20);
        mark();
        feed(432, 1'b1, -20, 100);
        wait_cycles(4);
        check_ssb("gapped");

        // restart mid-SSB after 200 REs
        do_start();
        mon_exp_data = pair(31, -31);
        mark();
        feed(200, 1'b0, -64, 64);
        do_start();
        wait_cycles(2);
        check("restart_writes", 32'(mon_wr - b_wr), 32'd200);
        check("restart_no_done", 32'(mon_done - b_done), 32'd0);
        check("restart_busy", 32'(d0_busy), 32'd1);
        mark();
        feed(432, 1'b0, -64, 64);
        wait_cycles(4);
        check_ssb("restart");

`ifdef PBCH_LLR_STATS_EN
        do_start();
        mon_exp_data = pair(16, 16);
        feed(432, 1'b0, 16, 16);
        wait_cycles(4);
        check("mag_sum_s0", 32'(d0_mag), 32'd13824);
        check("mag_sum_s2", 32'(d2_mag), 32'd3456);
        wait_cycles(5);
        check("mag_sum_hold", 32'(d0_mag), 32'd13824);
`endif

        // synchronous reset mid-SSB with a write pending
        do_start();
        mon_exp_data = pair(16, 16);
        feed(100, 1'b0, 16, 16);
        check("pre_rst_wr_en", 32'(d0_wr_en), 32'd1);
        in_valid = 1'b1;
        rst = 1'b1;
        step();
        check("mid_rst_outputs", 32'({d0_wr_en, d0_addr, d0_data, d0_done, d0_busy, d0_err}), 32'd0);
`ifdef PBCH_LLR_STATS_EN
        check("mid_rst_mag", 32'(d0_mag), 32'd0);
`endif
        rst = 1'b0;
        in_valid = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
